// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for the shared four-master system bus
//
// Grants the bus to one of four masters using active-low request/grant
// handshakes. The current owner keeps the bus while it requests. When it
// releases, the next requester in rotational order (owner+1, +2, +3) takes
// over. With nobody requesting the bus stays parked on the last owner.
// A non-zero HOLD_LIMIT forces a handoff once the owner has held the bus for
// HOLD_LIMIT consecutive cycles while some other master was waiting.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset (owner 0 granted)
//   mN_req_      master N bus request, active-low
//   mN_grnt_     master N grant, active-low, registered, exactly one low
//   owner        index of the granted master, registered
//   hold_expire  one-cycle pulse after a handoff forced by HOLD_LIMIT

module bus_arbiter #(
  parameter int unsigned HOLD_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       hold_expire
);

  typedef enum logic [1:0] {
    OWN0 = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    OWN3 = 2'd3
  } state_t;

  localparam logic       LIMIT_ON  = (HOLD_LIMIT != 0);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_LIMIT - 1);

  state_t     state_q, state_d;
  logic [3:0] grnt_q, grnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       hold_expire_q, hold_expire_d;

  logic [3:0] req;
  logic [1:0] own_idx;
  logic [1:0] next_idx;
  logic [1:0] rr_pick;
  logic [1:0] cand;
  logic       rr_found;
  logic       own_req;
  logic       contend;
  logic       force_handoff;

  // Active-high view of the requests, indexed by master number.
  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  always_comb begin
    own_idx  = state_q;
    own_req  = req[own_idx];
    rr_found = 1'b0;
    rr_pick  = own_idx;
    cand     = own_idx;
    // Walk from the farthest candidate to the nearest so that the closest
    // requester in rotational order is the one left in rr_pick.
    for (int k = 3; k >= 1; k--) begin
      cand = own_idx + 2'(k);
      if (req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end

    contend       = LIMIT_ON && own_req && rr_found;
    force_handoff = contend && (hold_cnt_q == HOLD_LAST);

    if ((!own_req || force_handoff) && rr_found) begin
      next_idx = rr_pick;
    end else begin
      next_idx = own_idx;
    end

    if (next_idx != own_idx) begin
      hold_cnt_d = 8'd0;
    end else if (contend) begin
      hold_cnt_d = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
    end else begin
      hold_cnt_d = 8'd0;
    end

    state_d       = state_t'(next_idx);
    grnt_d        = ~(4'b0001 << next_idx);
    hold_expire_d = force_handoff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= OWN0;
      grnt_q        <= 4'b1110;
      hold_cnt_q    <= 8'd0;
      hold_expire_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grnt_q        <= grnt_d;
      hold_cnt_q    <= hold_cnt_d;
      hold_expire_q <= hold_expire_d;
    end
  end

  assign owner       = state_q;
  assign m0_grnt_    = grnt_q[0];
  assign m1_grnt_    = grnt_q[1];
  assign m2_grnt_    = grnt_q[2];
  assign m3_grnt_    = grnt_q[3];
  assign hold_expire = hold_expire_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (limit 4 and limit 0)

module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;

  logic [3:0] g_a, g_b;
  logic [1:0] own_a, own_b;
  logic       exp_a, exp_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: index 0 models HOLD_LIMIT=4, index 1 HOLD_LIMIT=0.
  int mdl_owner [2];
  int mdl_cnt   [2];
  int mdl_exp   [2];
  int mdl_lim   [2] = '{4, 0};
  int waits     [4];

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_LIMIT(4)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g_a[0]), .m1_grnt_(g_a[1]), .m2_grnt_(g_a[2]), .m3_grnt_(g_a[3]),
    .owner(own_a), .hold_expire(exp_a)
  );

  bus_arbiter #(.HOLD_LIMIT(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g_b[0]), .m1_grnt_(g_b[1]), .m2_grnt_(g_b[2]), .m3_grnt_(g_b[3]),
    .owner(own_b), .hold_expire(exp_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdl_owner[i] = 0;
      mdl_cnt[i]   = 0;
      mdl_exp[i]   = 0;
    end
    for (int m = 0; m < 4; m++) waits[m] = 0;
  endtask

  // One clock of the arbitration rules, from the requests seen before the edge.
  task automatic model_advance(input int i, input logic [3:0] rq_n);
    int o, first, nxt;
    bit own_req, other, frc;
    o       = mdl_owner[i];
    own_req = (rq_n[o] == 1'b0);
    other   = 0;
    first   = o;
    for (int k = 1; k <= 3; k++) begin
      if (!other && rq_n[(o + k) % 4] == 1'b0) begin
        other = 1;
        first = (o + k) % 4;
      end
    end
    frc = (mdl_lim[i] > 0) && own_req && other && (mdl_cnt[i] == mdl_lim[i] - 1);
    nxt = ((!own_req || frc) && other) ? first : o;
    if (nxt != o)                                  mdl_cnt[i] = 0;
    else if (mdl_lim[i] > 0 && own_req && other)   mdl_cnt[i] = (mdl_cnt[i] < 255) ? mdl_cnt[i] + 1 : 255;
    else                                           mdl_cnt[i] = 0;
    mdl_owner[i] = nxt;
    mdl_exp[i]   = frc ? 1 : 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_owner_a"}, int'(own_a), mdl_owner[0]);
    chk({tag, "_grnt_a"},  int'(g_a),   int'(~(4'b0001 << mdl_owner[0]) & 4'hF));
    chk({tag, "_exp_a"},   int'(exp_a), mdl_exp[0]);
    chk({tag, "_owner_b"}, int'(own_b), mdl_owner[1]);
    chk({tag, "_grnt_b"},  int'(g_b),   int'(~(4'b0001 << mdl_owner[1]) & 4'hF));
    chk({tag, "_exp_b"},   int'(exp_b), mdl_exp[1]);
  endtask

  // Advance one clock: model from current requests, then sample after the edge.
  task automatic step(input string tag);
    logic [3:0] pre_req;
    logic [1:0] pre_own;
    pre_req = req_n;
    pre_own = own_a;
    if (reset) model_reset();
    else begin
      model_advance(0, pre_req);
      model_advance(1, pre_req);
    end
    @(posedge clk);
    #1;
    compare_all(tag);
    // Starvation bound: handoffs seen by a master that kept requesting.
    if (!reset && own_a != pre_own) begin
      for (int m = 0; m < 4; m++) begin
        if (pre_req[m] == 1'b0 && m != int'(own_a)) waits[m]++;
        else waits[m] = 0;
        if (waits[m] > 3) chk("starve", waits[m], 3);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_n = 4'hF;
    model_reset();
    #1;
    chk("rst_async_owner", int'(own_a), 0);
    chk("rst_async_grnt",  int'(g_a), 4'b1110);
    @(posedge clk);
    #1;
    compare_all("rst");
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      step("idle");
      chk("idle_owner", int'(own_a), 0);
    end

    req_n = 4'b1011; step("to2");
    chk("to2_owner", int'(own_a), 2);
    chk("to2_grnt",  int'(g_a), 4'b1011);
    req_n = 4'b1111;
    for (int c = 0; c < 3; c++) step("park2");
    chk("park2_owner", int'(own_b), 2);

    req_n = 4'b1101; step("to1");
    chk("to1_owner", int'(own_a), 1);
    req_n = 4'b0010; step("rr2");
    chk("rr2_owner", int'(own_a), 2);
    req_n = 4'b0110; step("rr3");
    chk("rr3_owner", int'(own_a), 3);
    req_n = 4'b1100; step("rr0");
    chk("rr0_owner", int'(own_a), 0);
    req_n = 4'b1101; step("rr1");
    chk("rr1_owner", int'(own_a), 1);

    req_n = 4'b1110; step("back0");
    req_n = 4'b0110;
    for (int c = 1; c <= 10; c++) begin
      step("hold");
      if (c == 3) chk("hold_pre_owner", int'(own_a), 0);
      if (c == 4) begin
        chk("hold_force_owner", int'(own_a), 3);
        chk("hold_force_exp",   int'(exp_a), 1);
      end
      if (c == 5) chk("hold_exp_pulse", int'(exp_a), 0);
      chk("nolimit_owner", int'(own_b), 0);
      chk("nolimit_exp",   int'(exp_b), 0);
    end

    req_n = 4'b0111; step("to3");
    chk("to3_owner", int'(own_b), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_owner_a", int'(own_a), 0);
    chk("midrst_grnt_a",  int'(g_a), 4'b1110);
    chk("midrst_owner_b", int'(own_b), 0);
    chk("midrst_exp_a",   int'(exp_a), 0);
    model_reset();
    step("inrst");
    reset = 1'b0;
    req_n = 4'b0110;
    for (int c = 1; c <= 5; c++) begin
      step("posthold");
      if (c == 4) chk("posthold_force", int'(own_a), 3);
    end

    for (int c = 0; c < 10000; c++) begin
      req_n = 4'($urandom_range(0, 15));
      step("rand");
      chk("onehot_a", $countones(~g_a), 1);
      chk("onehot_b", $countones(~g_b), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
